// File: rtl/bitvec_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitvec_serializer_if                                                 |
// | Handshake and serial-line bundle for bitvec_serializer.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface bitvec_serializer_if #(
  parameter int BIT_WIDTH = 8
);
  logic [BIT_WIDTH-1:0] din;
  logic                 start;
  logic                 stop;
  logic                 dout;
  logic                 dout_valid;
  logic                 frame_start;
  logic                 busy;
  logic                 done;

  modport master (
    output din,
    output start,
    output stop,
    input  dout,
    input  dout_valid,
    input  frame_start,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  start,
    input  stop,
    output dout,
    output dout_valid,
    output frame_start,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/bitvec_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bitvec_serializer                                                    |
// | Registered parallel-to-serial stage with repeat count and reload.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bitvec_serializer #(
  parameter int BIT_WIDTH    = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int REPEAT_COUNT = 0
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  bitvec_serializer_if.slave io_bus
);

  localparam int               CNT_W        = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_LAST_BIT   = CNT_W'(BIT_WIDTH - 1);
  localparam logic [15:0]      c_LAST_FRAME = 16'(REPEAT_COUNT - 1);
  localparam bit               c_FINITE     = (REPEAT_COUNT != 0);
  localparam logic [0:0]       c_IDLE       = 1'b0;
  localparam logic [0:0]       c_SHIFT      = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [BIT_WIDTH-1:0] r_shift;
  logic [BIT_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [15:0]          r_frame_cnt;
  logic                 r_done_pend;

  logic                 w_cur_bit;
  logic                 w_accept;
  logic                 w_shifting;
  logic                 w_end_frame;
  logic                 w_last_frame;
  logic                 w_finish;

  logic                 r_dout;
  logic                 r_dout_valid;
  logic                 r_frame_start;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_dout_d;
  logic                 w_dout_valid_d;
  logic                 w_frame_start_d;
  logic                 w_busy_d;
  logic                 w_done_d;

  // Current bit always sits at the outgoing end of the shift register.
  generate
    if (BIT_WIDTH == 1) begin : g_w1
      assign w_cur_bit   = r_shift[0];
      assign w_shift_nxt = '0;
    end else if (MSB_FIRST) begin : g_msb
      assign w_cur_bit   = r_shift[BIT_WIDTH-1];
      assign w_shift_nxt = {r_shift[BIT_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_cur_bit   = r_shift[0];
      assign w_shift_nxt = {1'b0, r_shift[BIT_WIDTH-1:1]};
    end
  endgenerate

  assign w_accept     = (r_state == c_IDLE) && io_bus.start && !io_bus.stop;
  assign w_shifting   = (r_state == c_SHIFT) && !io_bus.stop;
  assign w_end_frame  = (r_bit_cnt == c_LAST_BIT);
  assign w_last_frame = c_FINITE && (r_frame_cnt == c_LAST_FRAME);
  assign w_finish     = w_shifting && w_end_frame && w_last_frame;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_SHIFT;
        end
      end
      c_SHIFT: begin
        if (io_bus.stop || w_finish) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Next values of the registered outputs; done trails the last bit by one edge.
  always_comb begin
    w_dout_d        = 1'b0;
    w_dout_valid_d  = 1'b0;
    w_frame_start_d = 1'b0;
    w_busy_d        = 1'b0;
    w_done_d        = (r_state == c_IDLE) && r_done_pend;
    if (w_shifting) begin
      w_dout_d        = w_cur_bit;
      w_dout_valid_d  = 1'b1;
      w_frame_start_d = (r_bit_cnt == '0);
      w_busy_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_done_pend   <= 1'b0;
      r_dout        <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done_pend   <= w_finish;
      r_dout        <= w_dout_d;
      r_dout_valid  <= w_dout_valid_d;
      r_frame_start <= w_frame_start_d;
      r_busy        <= w_busy_d;
      r_done        <= w_done_d;
      if (w_accept) begin
        r_shift     <= io_bus.din;
        r_bit_cnt   <= '0;
        r_frame_cnt <= '0;
      end else if (w_shifting) begin
        if (w_end_frame) begin
          r_shift   <= io_bus.din;
          r_bit_cnt <= '0;
          // Saturate so an endless run never aliases onto a finite end count.
          if (r_frame_cnt != 16'hFFFF) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end else begin
          r_shift   <= w_shift_nxt;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign io_bus.dout        = r_dout;
  assign io_bus.dout_valid  = r_dout_valid;
  assign io_bus.frame_start = r_frame_start;
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bitvec_serializer.sv
`default_nettype none
// Testbench for bitvec_serializer: four configurations run side by side
// against a frame/position reference model, plus directed test-plan checks.
module tb_bitvec_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] s_rstn;
  logic [3:0] s_start;
  logic [3:0] s_stop;
  logic [7:0] s_din [4];

  logic [3:0] ob_dout, ob_valid, ob_fs, ob_busy, ob_done;

  bitvec_serializer_if #(.BIT_WIDTH(8)) ifA ();
  bitvec_serializer_if #(.BIT_WIDTH(8)) ifB ();
  bitvec_serializer_if #(.BIT_WIDTH(8)) ifC ();
  bitvec_serializer_if #(.BIT_WIDTH(1)) ifD ();

  assign ifA.din = s_din[0];    assign ifA.start = s_start[0]; assign ifA.stop = s_stop[0];
  assign ifB.din = s_din[1];    assign ifB.start = s_start[1]; assign ifB.stop = s_stop[1];
  assign ifC.din = s_din[2];    assign ifC.start = s_start[2]; assign ifC.stop = s_stop[2];
  assign ifD.din = s_din[3][0]; assign ifD.start = s_start[3]; assign ifD.stop = s_stop[3];

  assign ob_dout  = {ifD.dout,        ifC.dout,        ifB.dout,        ifA.dout};
  assign ob_valid = {ifD.dout_valid,  ifC.dout_valid,  ifB.dout_valid,  ifA.dout_valid};
  assign ob_fs    = {ifD.frame_start, ifC.frame_start, ifB.frame_start, ifA.frame_start};
  assign ob_busy  = {ifD.busy,        ifC.busy,        ifB.busy,        ifA.busy};
  assign ob_done  = {ifD.done,        ifC.done,        ifB.done,        ifA.done};

  bitvec_serializer #(.BIT_WIDTH(8), .MSB_FIRST(1'b1), .REPEAT_COUNT(2)) u_dut_a (
    .clk(clk), .rstn(s_rstn[0]), .io_bus(ifA));
  bitvec_serializer #(.BIT_WIDTH(8), .MSB_FIRST(1'b0), .REPEAT_COUNT(2)) u_dut_b (
    .clk(clk), .rstn(s_rstn[1]), .io_bus(ifB));
  bitvec_serializer #(.BIT_WIDTH(8), .MSB_FIRST(1'b1), .REPEAT_COUNT(0)) u_dut_c (
    .clk(clk), .rstn(s_rstn[2]), .io_bus(ifC));
  bitvec_serializer #(.BIT_WIDTH(1), .MSB_FIRST(1'b1), .REPEAT_COUNT(3)) u_dut_d (
    .clk(clk), .rstn(s_rstn[3]), .io_bus(ifD));

  int p_w   [4] = '{8, 8, 8, 1};
  bit p_msb [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int p_rc  [4] = '{2, 2, 0, 3};

  // Model: the frame as a list of bits in send order, a position, frames sent.
  bit         m_act    [4];
  bit         m_pend   [4];
  int         m_pos    [4];
  int         m_frames [4];
  bit         m_pat    [4][8];
  logic [3:0] e_dout, e_valid, e_fs, e_busy, e_done;

  int n_checks = 0;
  int n_errors = 0;

  task automatic load(input int id);
    for (int i = 0; i < p_w[id]; i++) begin
      m_pat[id][i] = p_msb[id] ? s_din[id][p_w[id]-1-i] : s_din[id][i];
    end
    m_pos[id] = 0;
  endtask

  task automatic step(input int id);
    e_dout[id] = 1'b0; e_valid[id] = 1'b0; e_fs[id] = 1'b0;
    e_busy[id] = 1'b0; e_done[id] = 1'b0;
    if (!s_rstn[id]) begin
      m_act[id]  = 1'b0;
      m_pend[id] = 1'b0;
    end else if (!m_act[id]) begin
      e_done[id] = m_pend[id];
      m_pend[id] = 1'b0;
      if (s_start[id] && !s_stop[id]) begin
        load(id);
        m_act[id]    = 1'b1;
        m_frames[id] = 0;
      end
    end else if (s_stop[id]) begin
      m_act[id] = 1'b0;
    end else begin
      e_dout[id]  = m_pat[id][m_pos[id]];
      e_valid[id] = 1'b1;
      e_busy[id]  = 1'b1;
      e_fs[id]    = (m_pos[id] == 0);
      m_pos[id]++;
      if (m_pos[id] == p_w[id]) begin
        m_frames[id]++;
        if (p_rc[id] != 0 && m_frames[id] == p_rc[id]) begin
          m_act[id]  = 1'b0;
          m_pend[id] = 1'b1;
        end else begin
          load(id);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int id, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, id, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int id = 0; id < 4; id++) step(id);
    #1;
    for (int id = 0; id < 4; id++) begin
      chk("dout",        id, ob_dout[id],  e_dout[id]);
      chk("dout_valid",  id, ob_valid[id], e_valid[id]);
      chk("frame_start", id, ob_fs[id],    e_fs[id]);
      chk("busy",        id, ob_busy[id],  e_busy[id]);
      chk("done",        id, ob_done[id],  e_done[id]);
    end
  endtask

  logic [15:0] cap_a, cap_b, cap_d;
  int          fs_cnt;

  initial begin
    s_rstn = 4'h0; s_start = 4'h0; s_stop = 4'h0;
    for (int id = 0; id < 4; id++) s_din[id] = 8'h00;

    // Reset state.
    tick(); tick();
    s_rstn = 4'hF;
    tick();

    // Basic, LSB-with-reload, abort and width-1 runs launched together.
    s_din[0] = 8'hA5; s_din[1] = 8'h01; s_din[2] = 8'hFF; s_din[3] = 8'h01;
    s_start = 4'hF;
    tick();
    s_start = 4'h0;
    cap_a = '0; cap_b = '0; cap_d = '0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c <= 16) begin
        cap_a = {cap_a[14:0], ob_dout[0]};
        cap_b = {cap_b[14:0], ob_dout[1]};
      end
      if (c <= 3) cap_d = {cap_d[14:0], ob_dout[3] & ob_fs[3]};
      if (c == 17) begin
        chk("basic_done_c17", 0, ob_done[0], 1'b1);
        chk("basic_busy_c17", 0, ob_busy[0], 1'b0);
      end
      if (c == 4) chk("w1_done_c4", 3, ob_done[3], 1'b1);
      if (c == 20) chk("abort_valid_c20", 2, ob_valid[2], 1'b1);
      if (c == 21) chk("abort_valid_c21", 2, ob_valid[2], 1'b0);
      if (c == 4) s_din[1] = 8'h80;
      s_stop[2] = (c == 20);
    end
    s_stop = 4'h0;
    chk16("basic_pattern", cap_a, 16'hA5A5);
    chk16("lsb_reload_pattern", cap_b, 16'h8001);
    chk16("w1_pattern", cap_d, 16'h0007);

    // start and stop together in IDLE.
    s_start = 4'hF; s_stop = 4'hF;
    tick(); tick(); tick();
    s_start = 4'h0; s_stop = 4'h0;

    // start pulses mid-frame on the endless instance are ignored.
    s_din[2] = 8'h3C;
    s_start[2] = 1'b1;
    tick();
    s_start[2] = 1'b0;
    fs_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (ob_fs[2]) fs_cnt++;
      s_start[2] = (c == 5) || (c == 13);
    end
    chk16("midframe_fs_count", 16'(fs_cnt), 16'd4);
    s_start[2] = 1'b0;
    s_stop[2]  = 1'b1;
    tick();
    s_stop[2]  = 1'b0;

    // Reset in the middle of a run, then restart.
    s_start = 4'hF;
    tick();
    s_start = 4'h0;
    for (int c = 1; c <= 4; c++) tick();
    s_rstn = 4'h0;
    tick();
    chk("reset_clears_valid", 0, ob_valid[0], 1'b0);
    s_rstn = 4'hF;
    tick(); tick();
    s_start = 4'hF;
    tick();
    s_start = 4'h0;
    tick();
    chk("restart_fs", 0, ob_fs[0], 1'b1);
    chk("restart_valid", 0, ob_valid[0], 1'b1);
    for (int c = 0; c < 20; c++) tick();

    // Randomized traffic on all four instances.
    for (int c = 0; c < 3000; c++) begin
      for (int id = 0; id < 4; id++) begin
        s_start[id] = ($urandom_range(3) == 0);
        s_stop[id]  = ($urandom_range(63) == 0);
        s_rstn[id]  = ($urandom_range(299) != 0);
        if ($urandom_range(7) == 0) s_din[id] = 8'($urandom);
      end
      tick();
    end

    s_start = 4'h0; s_stop = 4'hF; s_rstn = 4'hF;
    tick();
    s_stop = 4'h0;
    for (int c = 0; c < 5; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bitvec_serializer.md
# bitvec_serializer

Parallel-to-serial stimulus stage that consumes a static bit vector from `bitvector` and drives it onto a single-bit line, one bit per clock. It sits directly downstream of `bitvector` in the stimulus library and feeds bit-level DUT inputs such as data lanes, PRBS checkers or digital control pins. It supports MSB/LSB-first ordering, a finite or infinite repeat count, and per-frame reloading so the pattern can change between frames.

## Interface
- `bit_width`, default 8: frame length in bits; legal range 1..256.
- `msb_first`, default 1: 1 sends `din[bit_width-1]` first; 0 sends `din[0]` first.
- `repeat_count`, default 0: number of frames per run; 0 means repeat until `stop`; legal range 0..65535.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rstn`  input  1  reset, synchronous, active-low.
- `din`  input  bit_width  parallel pattern, normally `bitvector.out`.
- `start`  input  1  level-sampled run request.
- `stop`  input  1  level-sampled abort request.
- `dout`  output  1  serial data bit (registered).
- `dout_valid`  output  1  high while `dout` carries a pattern bit.
- `frame_start`  output  1  high while `dout` carries bit 0 of a frame.
- `busy`  output  1  high in SHIFT.
- `done`  output  1  one-cycle pulse after the final bit of a finite run.

## Operation
- Internal state: FSM {IDLE, SHIFT}, shift register `bit_width` bits wide, bit counter `$clog2(bit_width)` bits wide (minimum 1), 16-bit frame counter.
- Reset (`rstn`=0 at an edge): FSM goes to IDLE, shift register and counters clear, and all outputs go to 0.
- IDLE: `dout`, `dout_valid`, `frame_start` and `busy` are 0.
  - `start`=1 and `stop`=0: capture `din` into the shift register, clear both counters, go to SHIFT.
  - `start` and `stop` both 1: `stop` wins; stay in IDLE.
- SHIFT: each edge presents the next bit on `dout` with `dout_valid`=1 and `busy`=1.
  - Bit order follows `msb_first`.
  - `frame_start`=1 exactly when the bit counter is 0.
- End of frame (bit counter = `bit_width`-1):
  - Frames remaining, or `repeat_count`=0: resample `din` into the shift register, clear the bit counter and increment the frame counter. The next frame follows with no gap cycle.
  - `repeat_count`≠0 and frame counter = `repeat_count`-1: go to IDLE and pulse `done` on the following cycle.
- `stop`=1 in SHIFT aborts immediately. The next cycle is IDLE with all outputs 0 and no `done` pulse. A partial frame is discarded.
- `start` in SHIFT is ignored.
- `din` changes mid-frame do not affect the current frame. `din` is sampled only at `start` and at frame wrap.
- The frame counter saturates at 0xFFFF in infinite mode and never wraps into a false `done`.
- `bit_width`=1: every SHIFT cycle has `frame_start`=1 and reloads `din`.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled at edge k puts bit 0 on `dout` with `dout_valid`=1 and `frame_start`=1 after edge k+1. Latency is 1 cycle.
- A frame occupies exactly `bit_width` consecutive cycles. A run of N frames occupies N×`bit_width` cycles with no bubbles.
- `done` is high for exactly the one cycle after the last bit. `busy` is 0 in that same cycle.
- A new `start` is accepted in the `done` cycle (IDLE). Bit 0 then appears the cycle after.
- `stop` or `rstn`=0 at edge k clears the outputs after edge k. Reset takes priority over every other input.

## Test plan
- Basic run: `bit_width`=8, `msb_first`=1, `repeat_count`=2, `din`=8'hA5, `start` for 1 cycle. Required: `dout` = 1,0,1,0,0,1,0,1 twice over cycles 1–16; `frame_start` at cycles 1 and 9; `done` at cycle 17; `busy` 0 at cycle 17.
- LSB-first with reload: `msb_first`=0, `repeat_count`=2, `din`=8'h01 at start, then `din` changed to 8'h80 at cycle 4. Required: frame 1 = 1,0,0,0,0,0,0,0; frame 2 = 0,0,0,0,0,0,0,1.
- Abort: `repeat_count`=0, `din`=8'hFF, `stop` asserted at cycle 20. Required: `dout_valid`=1 through cycle 20, all outputs 0 from cycle 21, `done` never pulses.
- Simultaneous and ignored requests: `start`=`stop`=1 in IDLE keeps outputs 0. `start` pulsed mid-frame causes no restart; `frame_start` stays on an 8-cycle cadence.
- Reset mid-operation: `rstn`=0 at cycle 5 of a run clears all outputs the next cycle. After release, `start` alone is needed to begin again, and bit 0 appears 1 cycle later.
- Edge width: `bit_width`=1, `din`=1'b1, `repeat_count`=3. Required: `dout`=1 with `frame_start`=1 for cycles 1–3, and `done` at cycle 4.
